hq2x_linebuf: RTL and testbench

Multi-line ring buffer for the hq2x scaler input path. It generalises the two-bank ping-pong line store to NLINES banks, so the scaler can read any of the last NLINES-1 completed lines while the next line is written. Bank rotation, per-line length capture and overrun detection are internal; the producer only marks end-of-line and start-of-frame. The block sits between the video capture stage and the hq2x neighbourhood fetch logic.

---
 rtl/hq2x_linebuf.sv | 205 ++++++++++++++++++++
 tb/tb_hq2x_linebuf.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hq2x_linebuf.sv
// ---------------------------------------------------------------------------
// hq2x_linebuf
//
// Multi-line ring buffer feeding the hq2x neighbourhood fetch. NLINES banks
// of LENGTH words each: one bank is being written, the other NLINES-1 hold
// the most recent completed lines and can be read by age (rd_line 0 is the
// newest completed line). Bank rotation, per-line length capture and
// overrun detection are handled here; the producer only marks end-of-line
// and start-of-frame.
//
// Ports:
//   clk          sole clock, rising edge
//   reset_n      asynchronous active-low reset
//   wr_en        write wr_data at the write pointer of the current bank
//   wr_data      write word (DWIDTH+1 bits)
//   wr_eol       close the current line (a concurrent write is its last word)
//   wr_sof       start of frame: drop all completed lines, restart at bank 0
//   rd_en        read request
//   rd_line      line age to read, 0 = newest completed line
//   rd_addr      word address within the selected line
//   q            registered read data (0 on a miss, held when idle)
//   q_valid      the read returned a stored word
//   lines_valid  number of readable completed lines, 0..NLINES-1
//   wr_bank      bank currently being written
//   line_len     word count of the newest completed line, 0..LENGTH
//   overrun      sticky: a write was dropped because the line was full
// ---------------------------------------------------------------------------
module hq2x_linebuf #(
    parameter  int LENGTH = 256,
    parameter  int DWIDTH = 17,
    parameter  int NLINES = 3,
    localparam int AWIDTH = $clog2(LENGTH) - 1,
    localparam int LW     = (NLINES > 2) ? $clog2(NLINES) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DWIDTH:0]   wr_data,
    input  logic              wr_eol,
    input  logic              wr_sof,
    input  logic              rd_en,
    input  logic [LW-1:0]     rd_line,
    input  logic [AWIDTH:0]   rd_addr,
    output logic [DWIDTH:0]   q,
    output logic              q_valid,
    output logic [LW:0]       lines_valid,
    output logic [LW-1:0]     wr_bank,
    output logic [AWIDTH+1:0] line_len,
    output logic              overrun
);

    // Word counts span 0..LENGTH, one bit wider than an address.
    localparam int CW = AWIDTH + 2;
    // Read-bank arithmetic width: holds values up to 3*NLINES-2.
    localparam int RW = LW + 3;

    localparam logic [CW-1:0] LEN_MAX   = CW'(LENGTH);
    localparam logic [LW:0]   LV_MAX    = (LW + 1)'(NLINES - 1);
    localparam logic [LW-1:0] BANK_LAST = LW'(NLINES - 1);

    logic [DWIDTH:0] mem [NLINES][LENGTH];

    logic [CW-1:0]   wptr_q,        wptr_d;
    logic [LW-1:0]   wr_bank_q,     wr_bank_d;
    logic [LW:0]     lines_valid_q, lines_valid_d;
    logic [CW-1:0]   line_len_q,    line_len_d;
    logic            overrun_q,     overrun_d;
    logic [CW-1:0]   len_q [NLINES];
    logic [CW-1:0]   len_d [NLINES];
    logic [DWIDTH:0] q_q,           q_d;
    logic            q_valid_q,     q_valid_d;

    logic            wr_accept;
    logic [CW-1:0]   cnt;
    logic            mem_we;
    logic [LW-1:0]   mem_bank;
    logic [AWIDTH:0] mem_addr;

    logic [RW-1:0]   rsum;
    logic [LW-1:0]   rbank;
    logic            hit;

    // -----------------------------------------------------------------------
    // Write side: pointer, bank rotation, length capture, status.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        wptr_d        = wptr_q;
        wr_bank_d     = wr_bank_q;
        lines_valid_d = lines_valid_q;
        line_len_d    = line_len_q;
        overrun_d     = overrun_q;
        len_d         = len_q;
        mem_we        = 1'b0;
        mem_bank      = wr_bank_q;
        mem_addr      = wptr_q[AWIDTH:0];

        wr_accept = wr_en && (wptr_q < LEN_MAX);
        // Final count of the line if it closes this cycle.
        cnt       = wptr_q + CW'(wr_accept);

        if (wr_sof) begin
            // Start of frame wins over end-of-line; a concurrent word
            // becomes word 0 of the new frame's first line.
            wr_bank_d     = '0;
            lines_valid_d = '0;
            line_len_d    = '0;
            overrun_d     = 1'b0;
            mem_we        = wr_en;
            mem_bank      = '0;
            mem_addr      = '0;
            wptr_d        = wr_en ? CW'(1) : '0;
        end else begin
            mem_we = wr_accept;
            if (wr_en && !wr_accept) begin
                overrun_d = 1'b1;
            end
            if (wr_eol) begin
                len_d[wr_bank_q] = cnt;
                line_len_d       = cnt;
                wptr_d           = '0;
                wr_bank_d        = (wr_bank_q == BANK_LAST) ? '0
                                                            : wr_bank_q + LW'(1);
                lines_valid_d    = (lines_valid_q == LV_MAX)
                                   ? lines_valid_q
                                   : lines_valid_q + (LW + 1)'(1);
            end else begin
                wptr_d = cnt;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read side: the newest completed line sits just behind the write bank.
    // The sum is biased by 2*NLINES so it never goes negative for any
    // rd_line code, then folded back into 0..NLINES-1.
    // -----------------------------------------------------------------------
    always_comb begin
        rsum = RW'(wr_bank_q) + RW'(2 * NLINES - 1) - RW'(rd_line);
        if (rsum >= RW'(2 * NLINES)) begin
            rsum = rsum - RW'(2 * NLINES);
        end else if (rsum >= RW'(NLINES)) begin
            rsum = rsum - RW'(NLINES);
        end
        rbank = LW'(rsum);

        hit = rd_en
              && ({1'b0, rd_line} < lines_valid_q)
              && ({1'b0, rd_addr} < len_q[rbank]);

        q_d       = q_q;
        q_valid_d = hit;
        if (rd_en) begin
            if (hit) begin
                q_d = mem[rbank][rd_addr];
            end else begin
                q_d = '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q        <= '0;
            wr_bank_q     <= '0;
            lines_valid_q <= '0;
            line_len_q    <= '0;
            overrun_q     <= 1'b0;
            len_q         <= '{default: '0};
            q_q           <= '0;
            q_valid_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            wptr_q        <= wptr_d;
            wr_bank_q     <= wr_bank_d;
            lines_valid_q <= lines_valid_d;
            line_len_q    <= line_len_d;
            overrun_q     <= overrun_d;
            len_q         <= len_d;
            q_q           <= q_d;
            q_valid_q     <= q_valid_d;
        end
    end

    // NOTE: the line store has no reset; len[] and lines_valid gate every
    // read, so stale words are never returned and the array maps to RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_bank][mem_addr] <= wr_data;
        end
    end

    assign q           = q_q;
    assign q_valid     = q_valid_q;
    assign lines_valid = lines_valid_q;
    assign wr_bank     = wr_bank_q;
    assign line_len    = line_len_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_hq2x_linebuf.sv
// ---------------------------------------------------------------------------
// tb_hq2x_linebuf
//
// Self-checking bench for hq2x_linebuf (NLINES=3, LENGTH=256). Reads push
// their expected result onto a scoreboard queue when issued; a monitor pops
// and compares when the registered result appears. Status outputs are
// compared inline by each scenario task.
// ---------------------------------------------------------------------------
module tb_hq2x_linebuf;

    localparam int LENGTH = 256;
    localparam int DWIDTH = 17;
    localparam int NLINES = 3;
    localparam int AWIDTH = 7;
    localparam int LW     = 2;
    localparam int DW     = DWIDTH + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [DWIDTH:0]   wr_data = '0;
    logic              wr_eol = 1'b0;
    logic              wr_sof = 1'b0;
    logic              rd_en = 1'b0;
    logic [LW-1:0]     rd_line = '0;
    logic [AWIDTH:0]   rd_addr = '0;
    logic [DWIDTH:0]   q;
    logic              q_valid;
    logic [LW:0]       lines_valid;
    logic [LW-1:0]     wr_bank;
    logic [AWIDTH+1:0] line_len;
    logic              overrun;

    hq2x_linebuf #(.LENGTH(LENGTH), .DWIDTH(DWIDTH), .NLINES(NLINES)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_eol      (wr_eol),
        .wr_sof      (wr_sof),
        .rd_en       (rd_en),
        .rd_line     (rd_line),
        .rd_addr     (rd_addr),
        .q           (q),
        .q_valid     (q_valid),
        .lines_valid (lines_valid),
        .wr_bank     (wr_bank),
        .line_len    (line_len),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            v;
        logic [DWIDTH:0] d;
        string           name;
    } rd_exp_t;

    rd_exp_t sb[$];
    int      total = 0;
    int      bad   = 0;
    logic    rd_fired;

    // A read accepted on an edge has its result on q from that edge on.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_fired <= 1'b0;
        else          rd_fired <= rd_en;
    end

    always @(negedge clk) begin
        rd_exp_t e;
        if (rd_fired) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: read result with empty scoreboard, q=%h q_valid=%b",
                         q, q_valid);
            end else begin
                e = sb.pop_front();
                if (q_valid !== e.v || q !== e.d) begin
                    bad++;
                    $display("FAIL %s: q=%h q_valid=%b, required q=%h q_valid=%b",
                             e.name, q, q_valid, e.d, e.v);
                end
            end
        end
    end

    // One clock cycle of stimulus, applied just after a rising edge.
    task automatic step(input logic we, input logic [DWIDTH:0] wd, input logic eol,
                        input logic sof, input logic re, input logic [LW-1:0] rl,
                        input logic [AWIDTH:0] ra);
        wr_en   = we;
        wr_data = wd;
        wr_eol  = eol;
        wr_sof  = sof;
        rd_en   = re;
        rd_line = rl;
        rd_addr = ra;
        @(posedge clk);
        #1;
        wr_en  = 1'b0;
        wr_eol = 1'b0;
        wr_sof = 1'b0;
        rd_en  = 1'b0;
    endtask

    task automatic wr(input int d, input logic eol);
        step(1'b1, DW'(d), eol, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic push_exp(input logic v, input int d, input string name);
        rd_exp_t e;
        e.v    = v;
        e.d    = DW'(d);
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic rd(input int l, input int a, input logic v, input int d, input string name);
        push_exp(v, d, name);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, LW'(l), (AWIDTH + 1)'(a));
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({q, q_valid, lines_valid, wr_bank, line_len, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_init: q=%h qv=%b lv=%0d wb=%0d len=%0d ovr=%b, required all 0",
                     q, q_valid, lines_valid, wr_bank, line_len, overrun);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) wr('h50 + i, i == 3);
        total++;
        if ({lines_valid, wr_bank, line_len} !== {3'd1, 2'd1, 9'd4}) begin
            bad++;
            $display("FAIL pre_reset_status: lv=%0d wb=%0d len=%0d, required 1 1 4",
                     lines_valid, wr_bank, line_len);
        end
        rd(0, 2, 1'b1, 'h52, "pre_reset_rd");
        idle();
        total++;
        if (q_valid !== 1'b0 || q !== 18'h52) begin
            bad++;
            $display("FAIL idle_hold: q=%h qv=%b, required q=00052 qv=0", q, q_valid);
        end
        // Assert reset between edges: outputs must clear without a clock.
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({q, q_valid, lines_valid, wr_bank, line_len, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_async: q=%h qv=%b lv=%0d wb=%0d len=%0d ovr=%b, required all 0",
                     q, q_valid, lines_valid, wr_bank, line_len, overrun);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rd(0, 0, 1'b0, 0, "post_reset_rd");
        idle();
    endtask

    task automatic test_rotation();
        for (int i = 0; i < 9; i++) wr('h100 + i, 1'b0);
        // Closing read sees the pre-update lines_valid (0): a miss.
        push_exp(1'b0, 0, "eol_rd_pre_lines_valid");
        step(1'b1, DW'('h109), 1'b1, 1'b0, 1'b1, '0, '0);
        for (int i = 0; i < 12; i++) wr('h200 + i, i == 11);
        total++;
        if ({lines_valid, wr_bank, line_len} !== {3'd2, 2'd2, 9'd12}) begin
            bad++;
            $display("FAIL rot_status: lv=%0d wb=%0d len=%0d, required 2 2 12",
                     lines_valid, wr_bank, line_len);
        end
        rd(0, 11, 1'b1, 'h20B, "rot_line0_addr11");
        rd(1, 3, 1'b1, 'h103, "rot_line1_addr3");
        idle();
    endtask

    task automatic test_length_bound();
        rd(1, 10, 1'b0, 0, "len_past_end");
        rd(1, 9, 1'b1, 'h109, "len_last_word");
        rd(2, 0, 1'b0, 0, "line_not_valid");
        idle();
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) wr('h300 + i, 1'b0);
        // Read in the closing cycle resolves against the old newest line (B).
        push_exp(1'b1, 'h200, "eol_rd_old_newest");
        step(1'b1, DW'('h304), 1'b1, 1'b0, 1'b1, '0, '0);
        total++;
        if ({lines_valid, wr_bank, line_len} !== {3'd2, 2'd0, 9'd5}) begin
            bad++;
            $display("FAIL sat_status: lv=%0d wb=%0d len=%0d, required 2 0 5",
                     lines_valid, wr_bank, line_len);
        end
        rd(0, 0, 1'b1, 'h300, "after_eol_newest");
        rd(1, 0, 1'b1, 'h200, "sat_line1_is_b");
        rd(0, 4, 1'b1, 'h304, "c_last_word");
        rd(0, 5, 1'b0, 0, "c_past_end");
        idle();
    endtask

    task automatic test_overrun();
        for (int i = 0; i < LENGTH; i++) wr('h1000 + i, 1'b0);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL ovr_at_full: overrun=%b, required 0", overrun);
        end
        for (int i = LENGTH; i < LENGTH + 2; i++) wr('h1000 + i, 1'b0);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL ovr_set: overrun=%b, required 1", overrun);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        total++;
        if ({line_len, wr_bank, overrun, lines_valid} !== {9'd256, 2'd1, 1'b1, 3'd2}) begin
            bad++;
            $display("FAIL ovr_eol_status: len=%0d wb=%0d ovr=%b lv=%0d, required 256 1 1 2",
                     line_len, wr_bank, overrun, lines_valid);
        end
        rd(0, 255, 1'b1, 'h10FF, "ovr_word255");
        rd(0, 0, 1'b1, 'h1000, "ovr_word0");
        rd(1, 0, 1'b1, 'h300, "ovr_line1_is_c");
        idle();
    endtask

    task automatic test_sof();
        step(1'b1, DW'('h3FF), 1'b1, 1'b1, 1'b0, '0, '0);
        total++;
        if ({lines_valid, wr_bank, overrun, line_len} !== {3'd0, 2'd0, 1'b0, 9'd0}) begin
            bad++;
            $display("FAIL sof_status: lv=%0d wb=%0d ovr=%b len=%0d, required 0 0 0 0",
                     lines_valid, wr_bank, overrun, line_len);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        total++;
        if ({line_len, lines_valid, wr_bank} !== {9'd1, 3'd1, 2'd1}) begin
            bad++;
            $display("FAIL sof_eol_status: len=%0d lv=%0d wb=%0d, required 1 1 1",
                     line_len, lines_valid, wr_bank);
        end
        rd(0, 0, 1'b1, 'h3FF, "sof_word0");
        rd(0, 1, 1'b0, 0, "sof_past_end");
        rd(1, 0, 1'b0, 0, "sof_old_lines_gone");
        idle();
    endtask

    task automatic test_empty_line();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0, '0);
        total++;
        if ({line_len, lines_valid, wr_bank} !== {9'd0, 3'd2, 2'd2}) begin
            bad++;
            $display("FAIL empty_status: len=%0d lv=%0d wb=%0d, required 0 2 2",
                     line_len, lines_valid, wr_bank);
        end
        rd(0, 0, 1'b0, 0, "empty_line_rd");
        rd(1, 0, 1'b1, 'h3FF, "empty_prev_line");
        idle();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_length_bound();
        test_simultaneous();
        test_overrun();
        test_sof();
        test_empty_line();
        for (int i = 0; i < 10 && sb.size() != 0; i++) idle();
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_drain: %0d reads never answered, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
